// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: NREG read ports / write registers at BASE_ADR; `SPI_BURST_EN enables auto-increment bursts.
// Latency: sclk/cs pin to detect 3 clk, miso +1 clk, write commit 1 clk after last rise; no backpressure (master paced).
module spi_reg_bank #(
    parameter int NBIT     = 8,
    parameter int NREG     = 4,
    parameter int BASE_ADR = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sclk,
    input  logic                 i_mosi,
    input  logic                 i_cs,
    output logic                 o_miso,
    input  logic [NREG*NBIT-1:0] i_inport,
    output logic [NREG*NBIT-1:0] o_outport,
    output logic [NREG-1:0]      o_wr_strobe
);

    localparam int CW = 6;
    localparam int IW = 5;

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    // [0] first flop, [1] synchronised copy, [2] history for edge detect
    logic [2:0]      r_sclk_sy;
    logic [2:0]      r_cs_sy;
    logic [1:0]      r_mosi_sy;

    logic [CW-1:0]   r_bitcnt;
    logic [6:0]      r_cmd;
    logic [NBIT-2:0] r_rx;
    logic [NBIT-1:0] r_tx;
    logic            r_rw;
    logic            r_hit;
    logic            r_skip;
    logic [IW-1:0]   r_idx;

    logic            w_sclk_rise;
    logic            w_sclk_fall;
    logic            w_cs_rise;
    logic            w_cs_fall;
    logic            w_mosi;
    logic            w_frame_start;
    logic            w_cmd_rise;
    logic            w_cmd_last;
    logic            w_data_rise;
    logic            w_data_fall;
    logic            w_word_last;
    logic            w_miso_nxt;
    logic [7:0]      w_cmd_byte;
    logic            w_cmd_hit;
    logic [IW-1:0]   w_cmd_idx;
    logic [IW-1:0]   w_idx_inc;
    logic            w_inc_hit;
    logic [NBIT-1:0] w_word;
    logic [NBIT-1:0] w_in_cmd;
    logic [NBIT-1:0] w_in_inc;
    int              w_adr_i;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sy <= '0;
            r_cs_sy   <= '0;
            r_mosi_sy <= '0;
        end else begin
            r_sclk_sy <= {r_sclk_sy[1:0], i_sclk};
            r_cs_sy   <= {r_cs_sy[1:0], i_cs};
            r_mosi_sy <= {r_mosi_sy[0], i_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sy[1] & ~r_sclk_sy[2];
    assign w_sclk_fall = ~r_sclk_sy[1] & r_sclk_sy[2];
    assign w_cs_rise   = r_cs_sy[1] & ~r_cs_sy[2];
    assign w_cs_fall   = ~r_cs_sy[1] & r_cs_sy[2];
    assign w_mosi      = r_mosi_sy[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // cs rising always wins, including against a coincident last sclk rise
    always_comb begin
        w_next = r_state;
        if (w_cs_rise) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_next = S_CMD;
                S_CMD:   if (w_cmd_last) w_next = S_DATA;
                S_DATA:  if (w_word_last && !BURST) w_next = S_DONE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_frame_start = (r_state == S_IDLE) && w_cs_fall;
        w_cmd_rise    = (r_state == S_CMD) && w_sclk_rise && !w_cs_rise;
        w_cmd_last    = w_cmd_rise && (r_bitcnt == CW'(7));
        w_data_rise   = (r_state == S_DATA) && w_sclk_rise && !w_cs_rise;
        w_data_fall   = (r_state == S_DATA) && w_sclk_fall && !w_cs_rise;
        w_word_last   = w_data_rise && (r_bitcnt == CW'(NBIT-1));
        w_miso_nxt    = ((r_state == S_DATA) && !r_rw && r_hit) ? r_tx[NBIT-1] : 1'b1;
    end

    always_comb begin
        w_cmd_byte = {r_cmd, w_mosi};
        w_adr_i    = int'(w_cmd_byte[6:0]);
        w_cmd_hit  = (w_adr_i >= BASE_ADR) && (w_adr_i < BASE_ADR + NREG);
        w_cmd_idx  = IW'(w_adr_i - BASE_ADR);
        w_idx_inc  = r_idx + IW'(1);
        w_inc_hit  = r_hit && (int'(w_idx_inc) < NREG);
        w_word     = {r_rx, w_mosi};
        w_in_cmd   = '0;
        w_in_inc   = '0;
        for (int k = 0; k < NREG; k++) begin
            if (w_cmd_idx == IW'(k)) w_in_cmd = i_inport[k*NBIT +: NBIT];
            if (w_idx_inc == IW'(k)) w_in_inc = i_inport[k*NBIT +: NBIT];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bitcnt    <= '0;
            r_cmd       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_rw        <= 1'b0;
            r_hit       <= 1'b0;
            r_skip      <= 1'b0;
            r_idx       <= '0;
            o_miso      <= 1'b1;
            o_outport   <= '0;
            o_wr_strobe <= '0;
        end else begin
            o_wr_strobe <= '0;
            o_miso      <= w_miso_nxt;
            if (w_frame_start) begin
                r_bitcnt <= '0;
                r_cmd    <= '0;
                r_rx     <= '0;
                r_tx     <= '0;
                r_rw     <= 1'b0;
                r_hit    <= 1'b0;
                r_skip   <= 1'b0;
                r_idx    <= '0;
            end
            if (w_cmd_rise) begin
                r_cmd    <= w_cmd_byte[6:0];
                r_bitcnt <= r_bitcnt + CW'(1);
                if (w_cmd_last) begin
                    r_bitcnt <= '0;
                    r_rw     <= w_cmd_byte[7];
                    r_idx    <= w_cmd_idx;
                    r_hit    <= w_cmd_hit;
                    r_skip   <= 1'b1;
                    if (!w_cmd_byte[7] && w_cmd_hit) r_tx <= w_in_cmd;
                end
            end
            if (w_data_rise) begin
                r_rx     <= w_word[NBIT-2:0];
                r_bitcnt <= r_bitcnt + CW'(1);
                if (w_word_last) begin
                    r_bitcnt <= '0;
                    for (int k = 0; k < NREG; k++) begin
                        if (r_rw && r_hit && (r_idx == IW'(k))) begin
                            o_outport[k*NBIT +: NBIT] <= w_word;
                            o_wr_strobe[k]            <= 1'b1;
                        end
                    end
                    // burst: once the index runs past the bank the rest of the frame is a miss
                    if (BURST) begin
                        r_idx <= w_idx_inc;
                        r_hit <= w_inc_hit;
                        if (!r_rw && w_inc_hit) r_tx <= w_in_inc;
                    end
                end
            end
            if (w_data_fall && !r_rw) begin
                if (r_skip) r_skip <= 1'b0;
                else        r_tx   <= {r_tx[NBIT-2:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised SPI master against a word-level register-bank model; honours `SPI_BURST_EN.
module tb_spi_reg_bank;

    localparam int NBIT     = 8;
    localparam int NREG     = 4;
    localparam int BASE_ADR = 1;
    localparam int HALF     = 8;
`ifdef SPI_BURST_EN
    localparam int MAXW = 64;
`else
    localparam int MAXW = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sclk;
    logic                 mosi;
    logic                 cs;
    logic                 miso;
    logic [NREG*NBIT-1:0] inport;
    logic [NREG*NBIT-1:0] outport;
    logic [NREG-1:0]      strobe;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   strobe_cnt[NREG];
    int                   exp_cnt[NREG];
    logic [NREG*NBIT-1:0] model_out;
    logic [NREG*NBIT-1:0] inport_a;
    logic [NREG*NBIT-1:0] inport_b;
    logic [63:0]          rx;

    always #5 clk = ~clk;

    spi_reg_bank #(.NBIT(NBIT), .NREG(NREG), .BASE_ADR(BASE_ADR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sclk      (sclk),
        .i_mosi      (mosi),
        .i_cs        (cs),
        .o_miso      (miso),
        .i_inport    (inport),
        .o_outport   (outport),
        .o_wr_strobe (strobe)
    );

    always @(negedge clk) begin
        for (int k = 0; k < NREG; k++)
            if (strobe[k] === 1'b1) strobe_cnt[k]++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_inport();
        for (int k = 0; k < NREG; k++) inport[k*NBIT +: NBIT] = NBIT'($urandom);
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] dat, input int nb,
                             input bit simul, input int scr_at, input int rst_at,
                             output logic [63:0] rxo);
        rxo      = '1;
        inport_a = inport;
        inport_b = inport;
        cs = 1'b0;
        tick(HALF);
        for (int i = 0; i < 8; i++) begin
            mosi = cmd[7-i];
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
        for (int i = 0; i < nb; i++) begin
            int j, b;
            j = i / NBIT;
            b = NBIT - 1 - (i % NBIT);
            mosi = dat[j*NBIT + b];
            tick(HALF);
            rxo[j*NBIT + b] = miso;
            if (simul && i == nb - 1) cs = 1'b1;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            if (i == scr_at) begin
                rand_inport();
                inport_b = inport;
            end
            if (i == rst_at) begin
                tick(1);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                chk("rst_miso", miso, 1);
            end
        end
        tick(HALF);
        cs = 1'b1;
        tick(2*HALF);
    endtask

    // Word-level expectation of one frame: which register is addressed by each word,
    // what the master should see on reads and what each write leaves behind.
    task automatic model_frame(input logic [7:0] cmd, input logic [63:0] dat, input int nb,
                               input bit simul, input int rst_at, output logic [63:0] exp_rx);
        int adr, nread, nbe;
        adr    = int'(cmd[6:0]);
        exp_rx = '1;
        nread  = (rst_at >= 0) ? rst_at + 1 : nb;
        if (!cmd[7]) begin
            for (int i = 0; i < nread; i++) begin
                int j, s, idx, pos;
                logic [NREG*NBIT-1:0] src;
                logic [NBIT-1:0] wv;
                j   = i / NBIT;
                s   = i % NBIT;
                idx = adr - BASE_ADR + j;
                if (j < MAXW && adr >= BASE_ADR && idx < NREG) begin
                    src = (j == 0) ? inport_a : inport_b;
                    wv  = src[idx*NBIT +: NBIT];
                    // follow-on burst words: the fall after the load already shifts once
                    pos = (j == 0) ? NBIT - 1 - s : NBIT - 2 - s;
                    if (pos >= 0) exp_rx[j*NBIT + NBIT-1-s] = wv[pos];
                end
            end
        end
        if (rst_at >= 0) begin
            model_out = '0;
        end else if (cmd[7]) begin
            nbe = simul ? nb - 1 : nb;
            for (int j = 0; j < nbe / NBIT && j < MAXW; j++) begin
                int idx;
                idx = adr - BASE_ADR + j;
                if (adr >= BASE_ADR && idx < NREG) begin
                    model_out[idx*NBIT +: NBIT] = dat[j*NBIT +: NBIT];
                    exp_cnt[idx]++;
                end
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [63:0] dat, input int nb,
                             input bit simul, input int scr_at, input int rst_at);
        logic [63:0] exp_rx;
        spi_frame(cmd, dat, nb, simul, scr_at, rst_at, rx);
        model_frame(cmd, dat, nb, simul, rst_at, exp_rx);
        chk($sformatf("outport cmd=%h", cmd), outport, model_out);
        for (int k = 0; k < NREG; k++)
            chk($sformatf("strobes[%0d] cmd=%h", k, cmd), strobe_cnt[k], exp_cnt[k]);
        if (!cmd[7]) chk($sformatf("rdata cmd=%h nb=%0d", cmd, nb), rx, exp_rx);
        chk("idle_miso", miso, 1);
    endtask

    initial begin
        for (int k = 0; k < NREG; k++) begin
            strobe_cnt[k] = 0;
            exp_cnt[k]    = 0;
        end
        model_out = '0;
        rst    = 1'b1;
        cs     = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        inport = '0;
        tick(4);
        chk("reset_miso", miso, 1);
        chk("reset_outport", outport, 0);
        chk("reset_strobe", strobe, 0);
        rst = 1'b0;
        tick(4);
        chk("idle_miso_after_reset", miso, 1);

        run_frame(8'h82, 64'hA5, 8, 1'b0, -1, -1);
        chk("write_a5", outport, 32'h0000_A500);
        chk("write_strobe1", strobe_cnt[1], 1);

        inport = 32'h113C_2233;
        chk("read_pre_idle", miso, 1);
        run_frame(8'h03, 64'h0, 8, 1'b0, -1, -1);
        chk("read_3c", rx[7:0], 8'h3C);

        run_frame(8'h85, 64'hFF, 8, 1'b0, -1, -1);
        chk("miss_write", outport, 32'h0000_A500);
        run_frame(8'h05, 64'h0, 8, 1'b0, -1, -1);
        chk("miss_read", rx[7:0], 8'hFF);

        run_frame(8'h81, 64'h5A, 4, 1'b0, -1, -1);
        chk("abort_write", outport, 32'h0000_A500);
        run_frame(8'h81, 64'h77, 8, 1'b0, -1, -1);
        chk("after_abort", outport, 32'h0000_A577);

        run_frame(8'h84, 64'hC3, 8, 1'b1, -1, -1);
        chk("cs_with_last_rise", outport, 32'h0000_A577);

        cs = 1'b0;
        tick(4*HALF);
        cs = 1'b1;
        tick(2*HALF);
        run_frame(8'h84, 64'h3E, 8, 1'b0, -1, -1);
        chk("after_idle_cs", outport, 32'h3E00_A577);

        inport = 32'hAABB_CC96;
        run_frame(8'h01, 64'h0, 8, 1'b0, -1, 3);
        chk("rst_midread_data", rx[7:0], 8'h9F);
        chk("rst_outport", outport, 0);
        run_frame(8'h01, 64'h0, 8, 1'b0, -1, -1);
        chk("read_after_rst", rx[7:0], 8'h96);

        run_frame(8'h02, 64'h0, 8, 1'b0, 2, -1);
        chk("snapshot", rx[7:0], 8'hCC);

`ifdef SPI_BURST_EN
        run_frame(8'h81, 64'h0000_0055_4433_2211, 40, 1'b0, -1, -1);
        chk("burst_write", outport, 32'h4433_2211);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [7:0]  cmd;
            logic [63:0] dat;
            int          nw, nb, ab, scr;
            cmd[7]   = 1'($urandom_range(0, 1));
            cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(BASE_ADR - 1, BASE_ADR + NREG));
            dat = {$urandom, $urandom};
            nw  = $urandom_range(1, (MAXW > 1) ? 5 : 2);
            nb  = nw * NBIT;
            ab  = $urandom_range(0, 4);
            if (ab == 0) nb = $urandom_range(0, nb - 1);
            scr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NBIT - 2) : -1;
            rand_inport();
            run_frame(cmd, dat, nb, ab == 1, scr, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
